// File: rtl/pe_array_if.sv
// pe_array handshake bundle: advance enable, edge operands, accumulator bus.
// master drives operands; slave is the array.
interface pe_array_if #(
  parameter int rows = 4,
  parameter int cols = 4
);
  logic        fire;
  logic [7:0]  in_w [cols];
  logic [7:0]  in_a [rows];
  logic [11:0] outs [rows*cols];

  modport master (
    output fire,
    output in_w,
    output in_a,
    input  outs
  );

  modport slave (
    input  fire,
    input  in_w,
    input  in_a,
    output outs
  );
endinterface

// File: rtl/pe_array.sv
// Output-stationary rows x cols MAC systolic array.
// Define PE_ARR_SAT_EN to saturate accumulators at 4095 instead of wrapping.
module pe_array #(
  parameter int rows = 4,
  parameter int cols = 4
) (
  input  logic        clk,
  input  logic        rstn,
  pe_array_if.slave   bus
);

  logic [7:0]  a_reg   [rows][cols];
  logic [7:0]  w_reg   [rows][cols];
  logic [11:0] acc     [rows][cols];
  logic [7:0]  a_op    [rows][cols];
  logic [7:0]  w_op    [rows][cols];
  logic [11:0] acc_nxt [rows][cols];

  for (genvar r = 0; r < rows; r++) begin : g_row
    for (genvar c = 0; c < cols; c++) begin : g_col
      logic [15:0] prod;

      // Edge PEs take the array inputs, inner PEs take the neighbour register.
      if (c == 0) begin : g_a_edge
        assign a_op[r][c] = bus.in_a[r];
      end else begin : g_a_inner
        assign a_op[r][c] = a_reg[r][c-1];
      end

      if (r == 0) begin : g_w_edge
        assign w_op[r][c] = bus.in_w[c];
      end else begin : g_w_inner
        assign w_op[r][c] = w_reg[r-1][c];
      end

      assign prod = {8'd0, a_op[r][c]} * {8'd0, w_op[r][c]};

`ifdef PE_ARR_SAT_EN
      logic [16:0] sum;
      assign sum = {5'd0, acc[r][c]} + {1'b0, prod};
      assign acc_nxt[r][c] = (sum > 17'd4095) ? 12'hfff : sum[11:0];
`else
      assign acc_nxt[r][c] = acc[r][c] + prod[11:0];
`endif

      assign bus.outs[r*cols+c] = acc[r][c];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int r = 0; r < rows; r++) begin
        for (int c = 0; c < cols; c++) begin
          a_reg[r][c] <= '0;
          w_reg[r][c] <= '0;
          acc[r][c]   <= '0;
        end
      end
    end else if (bus.fire) begin
      for (int r = 0; r < rows; r++) begin
        for (int c = 0; c < cols; c++) begin
          a_reg[r][c] <= a_op[r][c];
          w_reg[r][c] <= w_op[r][c];
          acc[r][c]   <= acc_nxt[r][c];
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_array.sv
// Scoreboard bench for pe_array: stimulus pushes cycle-tagged
// expected accumulator vectors, a negedge monitor pops and compares.
module tb_pe_array;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  pe_array_if #(.rows(4), .cols(4)) bus();

  pe_array #(.rows(4), .cols(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct packed {
    int           cyc;
    logic [191:0] v;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   ta [4];
  int   tw [4];
  int   ex [16];
  int   amat [4][4];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: the tag marks the cycle at which the vector is due.
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      if (e.cyc != cyc) begin
        total++;
        bad++;
        $display("FAIL sb_tag got=%0d want=%0d", cyc, e.cyc);
      end
      for (int i = 0; i < 16; i++) begin
        total++;
        if (bus.outs[i] !== e.v[i*12 +: 12]) begin
          bad++;
          $display("FAIL outs[%0d] cyc=%0d got=%0d want=%0d",
                   i, cyc, bus.outs[i], e.v[i*12 +: 12]);
        end
      end
    end
  end

  task automatic clr_in();
    for (int i = 0; i < 4; i++) begin
      ta[i] = 0;
      tw[i] = 0;
    end
  endtask

  task automatic set_ex(input int val);
    for (int i = 0; i < 16; i++) ex[i] = val;
  endtask

  task automatic step(input bit f, input bit rn, input bit chk);
    exp_t e;
    @(posedge clk);
    #1;
    rstn     = rn;
    bus.fire = f;
    for (int i = 0; i < 4; i++) begin
      bus.in_a[i] = ta[i][7:0];
      bus.in_w[i] = tw[i][7:0];
    end
    if (chk) begin
      e.cyc = cyc + 1;
      for (int i = 0; i < 16; i++) e.v[i*12 +: 12] = ex[i][11:0];
      sbq.push_back(e);
    end
  endtask

  initial begin
    amat = '{'{1, 2, 3, 4}, '{5, 6, 7, 8}, '{1, 0, 0, 1}, '{2, 2, 2, 2}};
    rstn = 1'b0;
    bus.fire = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_a[i] = '0;
      bus.in_w[i] = '0;
    end

    // reset overrides fire with nonzero operands
    ta = '{7, 7, 7, 7};
    tw = '{9, 9, 9, 9};
    set_ex(0);
    step(1, 0, 1);
    step(1, 0, 1);

    // single MAC, then hold
    clr_in();
    ta[0] = 3;
    tw[0] = 5;
    ex[0] = 15;
    step(1, 1, 1);
    clr_in();
    step(1, 1, 1);
    step(1, 1, 1);

    clr_in();
    set_ex(0);
    step(1, 0, 1);

    // propagation along row 0
    tw = '{1, 1, 1, 1};
    ta[0] = 2;
    ex[0] = 2;
    step(1, 1, 1);
    ta[0] = 0;
    for (int i = 1; i < 4; i++) begin
      ex[i] = 2;
      step(1, 1, 1);
    end
    step(1, 1, 1);

    clr_in();
    set_ex(0);
    step(1, 0, 1);

    // propagation with a 3-cycle stall carrying junk inputs
    tw = '{1, 1, 1, 1};
    ta[0] = 2;
    ex[0] = 2;
    step(1, 1, 1);
    ta = '{9, 9, 9, 9};
    tw = '{9, 9, 9, 9};
    for (int i = 0; i < 3; i++) step(0, 1, 1);
    clr_in();
    tw = '{1, 1, 1, 1};
    for (int i = 1; i < 4; i++) begin
      ex[i] = 2;
      step(1, 1, 1);
    end

    clr_in();
    set_ex(0);
    step(1, 0, 1);

    // C = A x I with skewed feeding
    for (int t = 0; t < 10; t++) begin
      for (int r = 0; r < 4; r++)
        ta[r] = (t - r >= 0 && t - r < 4) ? amat[r][t-r] : 0;
      for (int c = 0; c < 4; c++)
        tw[c] = (t == 2 * c) ? 1 : 0;
      for (int i = 0; i < 16; i++) ex[i] = amat[i/4][i%4];
      step(1, 1, t == 9);
    end
    clr_in();
    step(1, 1, 1);
    step(0, 1, 1);

    // reset discards accumulated results
    set_ex(0);
    step(1, 0, 1);

    // overflow at PE(0,0)
    ta[0] = 255;
    tw[0] = 255;
`ifdef PE_ARR_SAT_EN
    ex[0] = 4095;
`else
    ex[0] = 3585;
`endif
    step(1, 1, 1);
`ifdef PE_ARR_SAT_EN
    ex[0] = 4095;
`else
    ex[0] = 3074;
`endif
    step(1, 1, 1);
    clr_in();
    step(1, 1, 1);

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    #2;
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_drain got=%0d want=0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
